// File: rtl/channel_arbiter_pkg.sv
// Shared front-end/arbiter types: request-word flag positions, type encoding
// and the read/write grouping mode enum.
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TYPE_POS
`define TYPE_POS 30
`endif

package channel_arbiter_pkg;

  localparam int ARB_BANKS = 16;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after ptr,
// with wrap-around, found by priority-encoding a doubled copy of the mask.
module rr_picker #(
  parameter int BANKS = 16
) (
  input  logic [BANKS-1:0]         mask,
  input  logic [$clog2(BANKS)-1:0] ptr,
  output logic [BANKS-1:0]         grant,
  output logic [$clog2(BANKS)-1:0] idx,
  output logic                     any
);

  localparam int PTR_W = $clog2(BANKS);
  localparam int SEL_W = PTR_W + 1;

  logic [2*BANKS-1:0] dbl;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_wrapped;

  assign dbl = {mask, mask};
  assign any = |mask;

  // Descending scan so the lowest qualifying position is the one left in sel;
  // the upper copy supplies the wrap-around candidates below ptr.
  always_comb begin
    sel = '0;
    for (int i = 2*BANKS-1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr))) sel = SEL_W'(i);
    end
  end

  assign sel_wrapped = (sel >= SEL_W'(BANKS)) ? (sel - SEL_W'(BANKS)) : sel;
  assign idx         = sel_wrapped[PTR_W-1:0];
  assign grant       = any ? (BANKS'(1) << idx) : '0;

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin channel arbiter feeding the DRAM command stage over valid/ready.
// Optional read/write grouping FSM enabled by CHANNEL_ARB_TYPE_GROUPING_EN.
module channel_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int BANKS     = ARB_BANKS,
  parameter int REQ_SIZE  = 32,
  parameter int VALID_POS = `VALID_POS,
  parameter int TYPE_POS  = `TYPE_POS,
  parameter int MAX_GROUP = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BANKS-1:0][REQ_SIZE-1:0]   req_i,
  output logic [BANKS-1:0]                 grant_o,
  output logic                             cmd_valid_o,
  input  logic                             cmd_ready_i,
  output logic [REQ_SIZE-1:0]              cmd_o,
  output logic [$clog2(BANKS)-1:0]         cmd_bank_o
);

  localparam int PTR_W = $clog2(BANKS);

  logic [BANKS-1:0] candidate;
  logic [BANKS-1:0] eligible;
  logic [BANKS-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] rr_ptr;
  logic             pick_any;
  logic             slot_free;
  logic             do_grant;

  always_comb begin
    candidate = '0;
    for (int b = 0; b < BANKS; b++) candidate[b] = req_i[b][VALID_POS];
  end

  assign slot_free = !cmd_valid_o || cmd_ready_i;

`ifdef CHANNEL_ARB_TYPE_GROUPING_EN
  localparam int GRP_W = $clog2(MAX_GROUP + 1);

  arb_mode_e        mode, mode_next;
  logic [GRP_W-1:0] grp_cnt, grp_next;
  logic [BANKS-1:0] is_write, same_mask, other_mask;
  logic             switch_mode;

  // Switch type when the current one has nothing pending, or when the group
  // limit is reached and the other type is waiting.
  always_comb begin
    is_write = '0;
    for (int b = 0; b < BANKS; b++) is_write[b] = (req_i[b][TYPE_POS] == REQ_WRITE);
    same_mask   = candidate & ((mode == WR) ? is_write : ~is_write);
    other_mask  = candidate & ~same_mask;
    switch_mode = (same_mask == '0) ||
                  ((grp_cnt == GRP_W'(MAX_GROUP)) && (other_mask != '0));
    eligible    = switch_mode ? other_mask : same_mask;
  end

  always_comb begin
    mode_next = mode;
    grp_next  = grp_cnt;
    if (do_grant) begin
      if (switch_mode) begin
        mode_next = (mode == RD) ? WR : RD;
        grp_next  = GRP_W'(1);
      end else if (grp_cnt < GRP_W'(MAX_GROUP)) begin
        grp_next  = grp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= RD;
      grp_cnt <= '0;
    end else begin
      mode    <= mode_next;
      grp_cnt <= grp_next;
    end
  end
`else
  logic unused_cfg;

  assign eligible   = candidate;
  assign unused_cfg = ^{TYPE_POS[0], MAX_GROUP[0], REQ_READ, REQ_WRITE};
`endif

  rr_picker #(.BANKS(BANKS)) u_picker (
    .mask  (eligible),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign do_grant = !rst && slot_free && pick_any;
  assign grant_o  = do_grant ? pick_grant : '0;

  // Output slot: load on a grant, drain on a handshake with no new winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_bank_o  <= '0;
      rr_ptr      <= '0;
    end else if (do_grant) begin
      cmd_valid_o <= 1'b1;
      cmd_o       <= req_i[pick_idx];
      cmd_bank_o  <= pick_idx;
      rr_ptr      <= (pick_idx == PTR_W'(BANKS-1)) ? '0 : pick_idx + 1'b1;
    end else if (cmd_ready_i) begin
      cmd_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter against a spec-level cycle model;
// grouping scenarios run when CHANNEL_ARB_TYPE_GROUPING_EN is defined.
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TYPE_POS
`define TYPE_POS 30
`endif

module tb_channel_arbiter;
  import channel_arbiter_pkg::*;

  localparam int B   = 16;
  localparam int W   = 32;
  localparam int VP  = `VALID_POS;
  localparam int TP  = `TYPE_POS;
  localparam int MAXG = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [B-1:0][W-1:0] req = '0;
  logic [B-1:0]       grant_o;
  logic               cmd_valid_o;
  logic               ready = 1'b0;
  logic [W-1:0]       cmd_o;
  logic [3:0]         cmd_bank_o;

  int checks = 0;
  int failures = 0;

  int          m_ptr, m_mode, m_grp, m_bank;
  logic        m_valid;
  logic [W-1:0] m_cmd;

  channel_arbiter #(.BANKS(B), .REQ_SIZE(W), .MAX_GROUP(MAXG)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .grant_o     (grant_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (ready),
    .cmd_o       (cmd_o),
    .cmd_bank_o  (cmd_bank_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [W-1:0] mk_req(input logic v, input logic t);
    logic [W-1:0] r;
    r = $urandom;
    r[VP] = v;
    r[TP] = t;
    return r;
  endfunction

  // Expected winner from the arbitration rules: -1 when nothing is granted.
  function automatic int model_pick(output int want);
    int n_same, n_other;
    want = m_mode;
    if (rst) return -1;
    if (m_valid && !ready) return -1;
`ifdef CHANNEL_ARB_TYPE_GROUPING_EN
    n_same = 0;
    n_other = 0;
    for (int b = 0; b < B; b++) begin
      if (req[b][VP]) begin
        if (int'(req[b][TP]) == m_mode) n_same++;
        else n_other++;
      end
    end
    if (n_same == 0 || (m_grp == MAXG && n_other > 0)) want = 1 - m_mode;
`else
    n_same = 0;
    n_other = 0;
`endif
    for (int k = 0; k < B; k++) begin
      int b;
      b = (m_ptr + k) % B;
`ifdef CHANNEL_ARB_TYPE_GROUPING_EN
      if (req[b][VP] && int'(req[b][TP]) == want) return b;
`else
      if (req[b][VP]) return b;
`endif
    end
    return -1;
  endfunction

  // One clock of stimulus already on the inputs; returns observed and model values.
  task automatic run_cycle(output logic [B-1:0] og, output logic [B-1:0] eg, output int win,
                           output logic ov, output logic ev, output logic [W-1:0] oc,
                           output logic [W-1:0] ec, output logic [3:0] ob, output logic [3:0] eb);
    int want;
    @(negedge clk);
    og  = grant_o;
    win = model_pick(want);
    eg  = (win >= 0) ? (B'(1) << win) : '0;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_cmd = '0; m_bank = 0; m_ptr = 0; m_mode = 0; m_grp = 0;
    end else if (win >= 0) begin
      m_valid = 1'b1;
      m_cmd   = req[win];
      m_bank  = win;
      m_ptr   = (win + 1) % B;
      if (want != m_mode) begin
        m_mode = want;
        m_grp  = 1;
      end else if (m_grp < MAXG) begin
        m_grp = m_grp + 1;
      end
    end else if (ready) begin
      m_valid = 1'b0;
    end
    #1;
    ov = cmd_valid_o;
    ev = m_valid;
    oc = cmd_o;
    ec = m_cmd;
    ob = cmd_bank_o;
    eb = 4'(m_bank);
  endtask

  logic [B-1:0] og, eg;
  logic         ov, ev;
  logic [W-1:0] oc, ec;
  logic [3:0]   ob, eb;
  int           win;

  task automatic do_reset();
    rst = 1'b1;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b1;
    for (int b = 0; b < B; b++) req[b] = mk_req(1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== '0) begin failures++; $display("[TB] FAIL reset_grant got=%h exp=0", og); end
      checks++;
      if (ov !== 1'b0 || oc !== '0 || ob !== 4'd0) begin
        failures++;
        $display("[TB] FAIL reset_outputs got v=%b cmd=%h bank=%0d exp v=0 cmd=0 bank=0", ov, oc, ob);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_two_banks();
    do_reset();
    req = '0;
    ready = 1'b1;
    req[3] = mk_req(1'b1, 1'b0);
    req[9] = mk_req(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== eg) begin failures++; $display("[TB] FAIL two_grant cyc=%0d got=%h exp=%h", i, og, eg); end
      checks++;
      if (ov !== ev || ob !== eb || oc !== ec) begin
        failures++;
        $display("[TB] FAIL two_cmd cyc=%0d got v=%b bank=%0d cmd=%h exp v=%b bank=%0d cmd=%h",
                 i, ov, ob, oc, ev, eb, ec);
      end
      if (win >= 0) req[win] = '0;
    end
    checks++;
    if (dut.rr_ptr !== 4'd10) begin failures++; $display("[TB] FAIL two_rr_ptr got=%0d exp=10", dut.rr_ptr); end
  endtask

  task automatic test_all_banks();
    do_reset();
    ready = 1'b1;
    for (int b = 0; b < B; b++) req[b] = mk_req(1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== (B'(1) << (i % B))) begin
        failures++; $display("[TB] FAIL all_grant cyc=%0d got=%h exp=%h", i, og, B'(1) << (i % B));
      end
      checks++;
      if (ov !== 1'b1 || ob !== 4'(i % B) || oc !== ec) begin
        failures++;
        $display("[TB] FAIL all_cmd cyc=%0d got v=%b bank=%0d cmd=%h exp v=1 bank=%0d cmd=%h",
                 i, ov, ob, oc, i % B, ec);
      end
      if (win >= 0) req[win] = mk_req(1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] first, second;
    do_reset();
    req = '0;
    ready = 1'b0;
    first = mk_req(1'b1, 1'b0);
    second = mk_req(1'b1, 1'b0);
    req[5] = first;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== 16'h0020 || ov !== 1'b1 || oc !== first) begin
      failures++; $display("[TB] FAIL bp_capture got g=%h v=%b cmd=%h exp g=0020 v=1 cmd=%h", og, ov, oc, first);
    end
    req[5] = second;
    for (int i = 0; i < 4; i++) begin
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== '0 || ov !== 1'b1 || oc !== first || ob !== 4'd5) begin
        failures++;
        $display("[TB] FAIL bp_hold cyc=%0d got g=%h v=%b cmd=%h bank=%0d exp g=0 v=1 cmd=%h bank=5",
                 i, og, ov, oc, ob, first);
      end
    end
    ready = 1'b1;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== 16'h0020 || oc !== second || ov !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_release got g=%h v=%b cmd=%h exp g=0020 v=1 cmd=%h", og, ov, oc, second);
    end
    req = '0;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== '0 || ov !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_drain got g=%h v=%b exp g=0 v=0", og, ov);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = '0;
    ready = 1'b0;
    req[2] = mk_req(1'b1, 1'b0);
    req[12] = mk_req(1'b1, 1'b0);
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    rst = 1'b1;
    ready = 1'b1;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== '0) begin failures++; $display("[TB] FAIL midrst_grant got=%h exp=0", og); end
    checks++;
    if (ov !== 1'b0 || dut.rr_ptr !== 4'd0) begin
      failures++; $display("[TB] FAIL midrst_state got v=%b ptr=%0d exp v=0 ptr=0", ov, dut.rr_ptr);
    end
    rst = 1'b0;
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== 16'h0004) begin failures++; $display("[TB] FAIL midrst_after got=%h exp=0004", og); end
    req = '0;
  endtask

`ifdef CHANNEL_ARB_TYPE_GROUPING_EN
  task automatic test_grouping();
    do_reset();
    req = '0;
    ready = 1'b1;
    for (int b = 0; b < 8; b++) req[b] = mk_req(1'b1, REQ_READ);
    req[8] = mk_req(1'b1, REQ_WRITE);
    for (int i = 0; i < 14; i++) begin
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== eg) begin failures++; $display("[TB] FAIL grp_grant cyc=%0d got=%h exp=%h", i, og, eg); end
      if (i < 8 || i == 8) begin
        checks++;
        if (ob !== 4'(i)) begin failures++; $display("[TB] FAIL grp_order cyc=%0d got=%0d exp=%0d", i, ob, i); end
      end
      if (i == 9) begin
        checks++;
        if (ob !== 4'd0 || dut.mode !== RD) begin
          failures++; $display("[TB] FAIL grp_back got bank=%0d mode=%0d exp bank=0 mode=0", ob, dut.mode);
        end
      end
      if (win >= 0) req[win] = mk_req(1'b1, REQ_READ);
    end
  endtask

  task automatic test_write_only();
    do_reset();
    req = '0;
    ready = 1'b1;
    req[4]  = mk_req(1'b1, REQ_WRITE);
    req[11] = mk_req(1'b1, REQ_WRITE);
    run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
    checks++;
    if (og !== 16'h0010 || ob !== 4'd4) begin
      failures++; $display("[TB] FAIL wr_first got g=%h bank=%0d exp g=0010 bank=4", og, ob);
    end
    checks++;
    if (dut.mode !== WR || dut.grp_cnt !== 4'd1) begin
      failures++; $display("[TB] FAIL wr_mode got mode=%0d grp=%0d exp mode=1 grp=1", dut.mode, dut.grp_cnt);
    end
    req = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int b = 0; b < B; b++) req[b] = mk_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        int b;
        b = $urandom_range(0, B-1);
        req[b] = mk_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run_cycle(og, eg, win, ov, ev, oc, ec, ob, eb);
      checks++;
      if (og !== eg) begin failures++; $display("[TB] FAIL rnd_grant cyc=%0d got=%h exp=%h", i, og, eg); end
      checks++;
      if (ov !== ev || (ev && (ob !== eb || oc !== ec))) begin
        failures++;
        $display("[TB] FAIL rnd_cmd cyc=%0d got v=%b bank=%0d cmd=%h exp v=%b bank=%0d cmd=%h",
                 i, ov, ob, oc, ev, eb, ec);
      end
      if (win >= 0) req[win] = mk_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  initial begin
    m_valid = 1'b0; m_cmd = '0; m_bank = 0; m_ptr = 0; m_mode = 0; m_grp = 0;
    $display("[TB] starting channel_arbiter bench");
    test_reset();
    test_two_banks();
    test_all_banks();
    test_backpressure();
    test_reset_mid();
`ifdef CHANNEL_ARB_TYPE_GROUPING_EN
    test_grouping();
    test_write_only();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
